norm_recip_iter: RTL and testbench

//  Sequential reciprocal unit directly downstream of the leading-zero normalizer in the
//  HOG block-normalisation path. Consumes a normalised mantissa (MSB=1) plus shift count.

---
 rtl/norm_recip_iter_pkg.sv | 24 ++
 rtl/norm_recip_iter_if.sv | 33 +++
 rtl/norm_recip_iter_recip_div_step.sv | 26 ++
 rtl/norm_recip_iter.sv | 121 ++++++++++++
 tb/tb_norm_recip_iter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/norm_recip_iter_pkg.sv
// Shared definitions for the reciprocal unit that follows the HOG
// block-normalisation leading-zero normaliser.
//   - state_e  : controller states (IDLE / DIV / DONE)
//   - *_DEF    : default widths (mantissa, shift count, quotient)
//   - iter_w() : width of the iteration counter for a given quotient width
package norm_recip_iter_pkg;

  localparam int unsigned IN_W_DEF  = 22;
  localparam int unsigned CNT_W_DEF = 5;
  localparam int unsigned Q_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned iter_w(input int unsigned q_w);
    return (q_w > 1) ? $clog2(q_w) : 1;
  endfunction

  localparam int unsigned ITER_W = iter_w(Q_W_DEF);

endpackage

// File: rtl/norm_recip_iter_if.sv
// Operand/result handshake bundle of the reciprocal unit.
//   in_valid/in_ready  : operand handshake (in_mant normalised, in_shift = lz count)
//   out_valid/out_ready: result handshake (out_recip, out_exp, out_zero)
// Modport slave is the unit's view; master is the view of the surrounding logic.
interface norm_recip_iter_if
  import norm_recip_iter_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned Q_W   = Q_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_mant;
  logic [CNT_W-1:0] in_shift;
  logic             out_valid;
  logic             out_ready;
  logic [Q_W-1:0]   out_recip;
  logic [CNT_W-1:0] out_exp;
  logic             out_zero;

  modport slave (
    input  in_valid, in_mant, in_shift, out_ready,
    output in_ready, out_valid, out_recip, out_exp, out_zero
  );

  modport master (
    output in_valid, in_mant, in_shift, out_ready,
    input  in_ready, out_valid, out_recip, out_exp, out_zero
  );

endinterface

// File: rtl/norm_recip_iter_recip_div_step.sv
// One combinational restoring-division step.
//   rem_i      : current partial remainder (IN_W+1 bits)
//   mant_i     : divisor (normalised mantissa)
//   rem_next_o : remainder for the next step, already shifted left by one
//   q_bit_o    : quotient bit produced by this step
module recip_div_step #(
  parameter int unsigned IN_W = 22
) (
  input  logic [IN_W:0]   rem_i,
  input  logic [IN_W-1:0] mant_i,
  output logic [IN_W:0]   rem_next_o,
  output logic            q_bit_o
);

  logic [IN_W:0] mant_ext;
  logic [IN_W:0] rem_sub;

  always_comb begin
    mant_ext   = {1'b0, mant_i};
    q_bit_o    = (rem_i >= mant_ext);
    rem_sub    = q_bit_o ? (rem_i - mant_ext) : rem_i;
    // rem_sub < mant_i, so the shifted-out MSB is always zero.
    rem_next_o = rem_sub << 1;
  end

endmodule

// File: rtl/norm_recip_iter.sv
// Sequential reciprocal of a normalised mantissa, one quotient bit per cycle.
//   clk, rst  : single clock, synchronous active-high reset
//   bus       : slave side of norm_recip_iter_if
//     in_*    : mantissa (MSB=1, or MSB=0 meaning zero operand) and shift count
//     out_*   : out_recip = floor(2^(IN_W+Q_W-2) / mant), out_exp = latched shift,
//               out_zero = zero operand (out_recip saturated to all ones)
// Result is held while out_valid && !out_ready; no new operand is taken
// until the result has been consumed.
module norm_recip_iter
  import norm_recip_iter_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned Q_W   = Q_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  norm_recip_iter_if.slave  bus
);

  localparam int unsigned   IW        = iter_w(Q_W);
  localparam logic [IW-1:0] ITER_LAST = IW'(Q_W - 1);
  // Initial remainder 2^(IN_W-1): first quotient bit weighs 2^(Q_W-1).
  localparam logic [IN_W:0] REM_INIT  = {2'b01, {(IN_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [IN_W-1:0]  mant_q,  mant_d;
  logic [IN_W:0]    rem_q,   rem_d;
  logic [Q_W-1:0]   q_q,     q_d;
  logic [IW-1:0]    iter_q,  iter_d;
  logic [CNT_W-1:0] exp_q,   exp_d;
  logic             zero_q,  zero_d;

  logic [IN_W:0]    rem_next;
  logic             q_bit;

  recip_div_step #(
    .IN_W (IN_W)
  ) u_step (
    .rem_i      (rem_q),
    .mant_i     (mant_q),
    .rem_next_o (rem_next),
    .q_bit_o    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      iter_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      iter_q  <= iter_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    rem_d   = rem_q;
    q_d     = q_q;
    iter_d  = iter_q;
    exp_d   = exp_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mant_d = bus.in_mant;
          exp_d  = bus.in_shift;
          rem_d  = REM_INIT;
          iter_d = '0;
          if (bus.in_mant[IN_W-1]) begin
            q_d     = '0;
            zero_d  = 1'b0;
            state_d = ST_DIV;
          end else begin
            // Zero operand: saturate immediately, skip iteration.
            q_d     = '1;
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DIV: begin
        q_d    = {q_q[Q_W-2:0], q_bit};
        rem_d  = rem_next;
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The quotient register doubles as the result register; it is only
  // observed while out_valid is high, after the last step has landed.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_recip = q_q;
  assign bus.out_exp   = exp_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_norm_recip_iter.sv
// Bench for norm_recip_iter (IN_W=22, CNT_W=5, Q_W=16): directed table,
// hold/stall and mid-division reset sequences, then random operands
// against floor(2^36/mant).
module tb_norm_recip_iter;

  localparam int unsigned IN_W  = 22;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned Q_W   = 16;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  norm_recip_iter_if #(.IN_W(IN_W), .CNT_W(CNT_W), .Q_W(Q_W)) bus ();

  norm_recip_iter #(.IN_W(IN_W), .CNT_W(CNT_W), .Q_W(Q_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [IN_W-1:0]  mant;
    logic [CNT_W-1:0] shift;
    logic [Q_W-1:0]   recip;
    logic             zero;
    int unsigned      lat;
  } vec_t;

  vec_t vecs[6];

  // Reference: reciprocal by plain integer division.
  function automatic logic [Q_W-1:0] ref_recip(input logic [IN_W-1:0] m);
    longint unsigned num;
    if (!m[IN_W-1]) return '1;
    num = 64'd1 << (IN_W + Q_W - 2);
    return Q_W'(num / longint'(m));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand, wait for the result, stall `stall` cycles, consume it.
  task automatic do_op(input logic [IN_W-1:0] mant, input logic [CNT_W-1:0] shift,
                       input int unsigned stall,
                       output logic [Q_W-1:0] r, output logic [CNT_W-1:0] e,
                       output logic z, output int unsigned lat);
    int unsigned n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_mant  = mant;
    bus.in_shift = shift;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    lat = n + 1;
    if (!bus.out_valid) check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    r = bus.out_recip;
    e = bus.out_exp;
    z = bus.out_zero;
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [Q_W-1:0]   r;
    logic [CNT_W-1:0] e;
    logic             z;
    int unsigned      lat;
    logic [IN_W-1:0]  m;
    logic [CNT_W-1:0] s;
    logic             stable;

    checks = 0;
    errors = 0;

    vecs[0] = '{mant: 22'h200000, shift: 5'd3,  recip: 16'h8000, zero: 1'b0, lat: 17};
    vecs[1] = '{mant: 22'h300000, shift: 5'd0,  recip: 16'h5555, zero: 1'b0, lat: 17};
    vecs[2] = '{mant: 22'h3FFFFF, shift: 5'd7,  recip: 16'h4000, zero: 1'b0, lat: 17};
    vecs[3] = '{mant: 22'h000000, shift: 5'd22, recip: 16'hFFFF, zero: 1'b1, lat: 1};
    vecs[4] = '{mant: 22'h200001, shift: 5'd1,  recip: 16'h7FFF, zero: 1'b0, lat: 17};
    vecs[5] = '{mant: 22'h100000, shift: 5'd1,  recip: 16'hFFFF, zero: 1'b1, lat: 1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();

    // Reset state (reset still asserted, then released).
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_recip", {16'd0, bus.out_recip}, 32'd0);
    check("rst_out_exp",   {27'd0, bus.out_exp},   32'd0);
    check("rst_out_zero",  {31'd0, bus.out_zero},  32'd0);
    rst = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].mant, vecs[i].shift, 0, r, e, z, lat);
      check($sformatf("vec%0d_recip", i), {16'd0, r}, {16'd0, vecs[i].recip});
      check($sformatf("vec%0d_exp", i),   {27'd0, e}, {27'd0, vecs[i].shift});
      check($sformatf("vec%0d_zero", i),  {31'd0, z}, {31'd0, vecs[i].zero});
      check($sformatf("vec%0d_lat", i),   lat, vecs[i].lat);
      check($sformatf("vec%0d_drop", i),  {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("vec%0d_ready", i), {31'd0, bus.in_ready},  32'd1);
    end

    // Hold: result stays put for 10 stalled cycles while a new operand is offered.
    bus.in_mant  = 22'h300000;
    bus.in_shift = 5'd9;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (16) tick();
    check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_mant  = 22'h200000;
    bus.in_shift = 5'd2;
    bus.in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.out_recip !== 16'h5555 ||
          bus.out_exp !== 5'd9 || bus.out_zero !== 1'b0) stable = 1'b0;
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    check("hold_recip",  {16'd0, bus.out_recip}, 32'h5555);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hold_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("hold_release_ready", {31'd0, bus.in_ready},  32'd1);

    // Reset at iteration 7 aborts the division.
    bus.in_mant  = 22'h3FFFFF;
    bus.in_shift = 5'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_out_recip", {16'd0, bus.out_recip}, 32'd0);
    check("abort_out_exp",   {27'd0, bus.out_exp},   32'd0);
    do_op(22'h300000, 5'd5, 2, r, e, z, lat);
    check("after_abort_recip", {16'd0, r}, 32'h5555);
    check("after_abort_exp",   {27'd0, e}, 32'd5);
    check("after_abort_lat",   lat, 32'd17);

    // Random operands with random stalls and idle gaps.
    for (int k = 0; k < 1000; k++) begin
      m = IN_W'($urandom);
      m[IN_W-1] = 1'b1;
      s = CNT_W'($urandom_range(0, 22));
      repeat ($urandom_range(0, 1)) tick();
      do_op(m, s, $urandom_range(0, 3), r, e, z, lat);
      check("rand_recip", {16'd0, r}, {16'd0, ref_recip(m)});
      check("rand_exp",   {27'd0, e}, {27'd0, s});
      check("rand_zero",  {31'd0, z}, 32'd0);
      check("rand_lat",   lat, 32'd17);
      check("rand_range", {31'd0, (r >= 16'h4000 && r <= 16'h8000)}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
